// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the instruction encoder.
// Holds the opcode and funct enums, the NOP word, immediate ranges,
// the request struct taken by the encoder and the encoded-word payload.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LW     = 7'b0000011,
    OP_ALU_I  = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_SW     = 7'b0100011,
    OP_ALU    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } f3_alu_t;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } f3_branch_t;

  typedef enum logic [6:0] {
    F7_ALU_NORMAL   = 7'b0000000,
    F7_ALU_MODIFIED = 7'b0100000
  } f7_alu_modifier_t;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [2:0]  F3_LW_SW = 3'b010;

  localparam int I_IMM_MIN = -2048;
  localparam int I_IMM_MAX = 2047;
  localparam int B_IMM_MIN = -4096;
  localparam int B_IMM_MAX = 4094;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] insn;
    logic        illegal;
  } enc_word_t;

endpackage

// File: rtl/riscv_skid_buffer.sv
// Two-entry skid buffer (main + skid register) for a generic payload type.
// Ports: in_valid_i/in_ready_o/in_data_i upstream, out_valid_o/out_ready_i/
// out_data_o downstream. in_ready_o is registered (= !skid_full), so there is
// no combinational path from out_ready_i back to in_ready_o.
module riscv_skid_buffer #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic ready_q, ready_d;
  logic in_fire, out_fire;

  always_comb begin
    in_fire      = in_valid_i & ready_q;
    out_fire     = main_valid_q & out_ready_i;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || out_fire) begin
      // Head slot frees up: refill from skid first to keep ordering.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = in_data_i;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/riscv_insn_encoder.sv
// RV32I subset instruction encoder (LW, ALU-I, AUIPC, SW, ALU, LUI, BRANCH).
// Decoded fields arrive on a valid/ready stream (in_*), packed words leave on
// a valid/ready stream (out_*) stamped with a sequential IMEM address.
// Illegal requests emit the NOP word with out_illegal_o set and are counted
// on acceptance in illegal_cnt_o (saturating). addr_load_i reloads the
// address counter (word aligned) and overrides a same-cycle increment.
module riscv_insn_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        in_opcode_i,
  input  logic [2:0]        in_f3_i,
  input  logic [6:0]        in_f7_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [31:0]       in_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_insn_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_illegal_o,
  input  logic              addr_load_i,
  input  logic [ADDR_W-1:0] addr_val_i,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  function automatic enc_word_t encode(input enc_req_t r);
    enc_word_t w;
    logic bad, f7_ok, is_shift, i_rng, b_rng;
    w.insn   = '0;
    bad      = 1'b0;
    f7_ok    = (r.f7 == F7_ALU_NORMAL) || (r.f7 == F7_ALU_MODIFIED);
    is_shift = (r.f3 == F3_SLL) || (r.f3 == F3_SRL_SRA);
    i_rng    = ($signed(r.imm) >= I_IMM_MIN) && ($signed(r.imm) <= I_IMM_MAX);
    b_rng    = ($signed(r.imm) >= B_IMM_MIN) && ($signed(r.imm) <= B_IMM_MAX);
    case (r.opcode)
      OP_ALU: begin
        bad = !f7_ok || ((r.f7 == F7_ALU_MODIFIED) &&
                         (r.f3 != F3_ADD_SUB) && (r.f3 != F3_SRL_SRA));
        w.insn = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.opcode};
      end
      OP_ALU_I: begin
        if (is_shift) begin
          bad = (r.imm[31:5] != '0) ||
                ((r.f3 == F3_SLL) ? (r.f7 != F7_ALU_NORMAL) : !f7_ok);
          w.insn = {r.f7, r.imm[4:0], r.rs1, r.f3, r.rd, r.opcode};
        end else begin
          bad = !i_rng;
          w.insn = {r.imm[11:0], r.rs1, r.f3, r.rd, r.opcode};
        end
      end
      OP_LW: begin
        bad = (r.f3 != F3_LW_SW) || !i_rng;
        w.insn = {r.imm[11:0], r.rs1, r.f3, r.rd, r.opcode};
      end
      OP_SW: begin
        bad = (r.f3 != F3_LW_SW) || !i_rng;
        w.insn = {r.imm[11:5], r.rs2, r.rs1, F3_LW_SW, r.imm[4:0], r.opcode};
      end
      OP_BRANCH: begin
        bad = (r.f3 == 3'b010) || (r.f3 == 3'b011) || r.imm[0] || !b_rng;
        w.insn = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3,
                  r.imm[4:1], r.imm[11], r.opcode};
      end
      OP_LUI, OP_AUIPC: begin
        bad = (r.imm[11:0] != '0);
        w.insn = {r.imm[31:12], r.rd, r.opcode};
      end
      default: bad = 1'b1;
    endcase
    if (bad) w.insn = INSN_NOP;
    w.illegal = bad;
    return w;
  endfunction

  enc_req_t  req;
  enc_word_t enc_word;
  enc_word_t head;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_fire;

  always_comb begin
    req.opcode = in_opcode_i;
    req.f3     = in_f3_i;
    req.f7     = in_f7_i;
    req.rd     = in_rd_i;
    req.rs1    = in_rs1_i;
    req.rs2    = in_rs2_i;
    req.imm    = in_imm_i;
    enc_word   = encode(req);
  end

  riscv_skid_buffer #(.T(enc_word_t)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (enc_word),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (head)
  );

  // The address is stamped on whatever word is at the head, so a reload
  // also retargets a word that is buffered but not yet accepted.
  always_comb begin
    out_fire = out_valid_o & out_ready_i;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    if (addr_load_i) begin
      addr_d = {addr_val_i[ADDR_W-1:2], 2'b00};
    end else if (out_fire) begin
      addr_d = addr_q + ADDR_W'(4);
    end
    if (out_fire && head.illegal && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= BASE_ADDR;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_insn_o    = head.insn;
  assign out_illegal_o = head.illegal;
  assign out_addr_o    = addr_q;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_insn_encoder.sv
// Directed bench for riscv_insn_encoder with a scoreboard queue: expected
// words are pushed when a request is accepted and popped when a word is
// accepted at the output.
module tb_riscv_insn_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  in_opcode_i;
  logic [2:0]  in_f3_i;
  logic [6:0]  in_f7_i;
  logic [4:0]  in_rd_i;
  logic [4:0]  in_rs1_i;
  logic [4:0]  in_rs2_i;
  logic [31:0] in_imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_insn_o;
  logic [31:0] out_addr_o;
  logic        out_illegal_o;
  logic        addr_load_i;
  logic [31:0] addr_val_i;
  logic [15:0] illegal_cnt_o;

  riscv_insn_encoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_opcode_i   (in_opcode_i),
    .in_f3_i       (in_f3_i),
    .in_f7_i       (in_f7_i),
    .in_rd_i       (in_rd_i),
    .in_rs1_i      (in_rs1_i),
    .in_rs2_i      (in_rs2_i),
    .in_imm_i      (in_imm_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_insn_o    (out_insn_o),
    .out_addr_o    (out_addr_o),
    .out_illegal_o (out_illegal_o),
    .addr_load_i   (addr_load_i),
    .addr_val_i    (addr_val_i),
    .illegal_cnt_o (illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] insn;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_addr;
  logic [15:0] m_cnt;
  logic [31:0] pend_insn;
  logic        pend_ill;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One clock: score any output handshake, log any input handshake,
  // advance the bench's address/count model, then clock.
  task automatic step();
    exp_t e;
    bit   ofire;
    e     = '0;
    ofire = out_valid_o && out_ready_i;
    if (ofire) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_word observed=%h expected=none", out_insn_o);
      end else begin
        e = sb.pop_front();
        chk("insn", {32'h0, out_insn_o}, {32'h0, e.insn});
        chk("illegal_flag", {63'h0, out_illegal_o}, {63'h0, e.ill});
        chk("addr", {32'h0, out_addr_o}, {32'h0, m_addr});
      end
    end
    if (in_valid_i && in_ready_o) sb.push_back({pend_insn, pend_ill});
    if (addr_load_i) m_addr = {addr_val_i[31:2], 2'b00};
    else if (ofire)  m_addr = m_addr + 32'd4;
    if (ofire && e.ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    tick();
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [31:0] exp_insn, input logic exp_ill);
    in_opcode_i = op;
    in_f3_i     = f3;
    in_f7_i     = f7;
    in_rd_i     = rd;
    in_rs1_i    = rs1;
    in_rs2_i    = rs2;
    in_imm_i    = imm;
    pend_insn   = exp_insn;
    pend_ill    = exp_ill;
    in_valid_i  = 1'b1;
  endtask

  task automatic wait_accept();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = in_ready_o;
      step();
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=in_ready_low expected=accept_within_20");
    end
  endtask

  task automatic req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm, input logic [31:0] exp_insn, input logic exp_ill);
    drive(op, f3, f7, rd, rs1, rs2, imm, exp_insn, exp_ill);
    wait_accept();
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    tick();
    tick();
    rst_i  = 1'b0;
    sb.delete();
    m_addr = 32'h0;
    m_cnt  = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    addr_load_i = 1'b0;
    addr_val_i  = 32'h0;
    drive(7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 32'h0, 32'h0, 1'b0);
    in_valid_i  = 1'b0;
    do_reset();

    // Reset state
    chk("rst_out_valid", {63'h0, out_valid_o}, 64'h0);
    chk("rst_out_insn", {32'h0, out_insn_o}, 64'h0);
    chk("rst_out_illegal", {63'h0, out_illegal_o}, 64'h0);
    chk("rst_out_addr", {32'h0, out_addr_o}, 64'h0);
    chk("rst_illegal_cnt", {48'h0, illegal_cnt_o}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready_o}, 64'h1);

    // ALU add / sub, addresses 0x0 then 0x4 via the address model
    req(OPC_ALU, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
    chk("latency_valid", {63'h0, out_valid_o}, 64'h1);
    chk("first_addr", {32'h0, out_addr_o}, 64'h0);
    req(OPC_ALU, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b0);
    chk("second_addr", {32'h0, out_addr_o}, 64'h4);

    // ALU-I / SW / BRANCH / LUI, back to back
    req(OPC_ALU_I, 3'b000, 7'h0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
    req(OPC_SW, 3'b010, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
    req(OPC_BRANCH, 3'b000, 7'h0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
    req(OPC_LUI, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 32'h123450B7, 1'b0);
    // Boundary and shift forms
    req(OPC_ALU_I, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h80000093, 1'b0);
    req(OPC_ALU_I, 3'b001, 7'h0, 5'd1, 5'd1, 5'd0, 32'd31, 32'h01F09093, 1'b0);
    req(OPC_ALU_I, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093, 1'b0);
    idle(3);
    chk("cnt_before_illegal", {48'h0, illegal_cnt_o}, 64'h0);

    // Illegal requests
    req(OPC_BRANCH, 3'b000, 7'h0, 5'd0, 5'd1, 5'd2, 32'd3, NOP, 1'b1);
    idle(2);
    chk("cnt_after_branch", {48'h0, illegal_cnt_o}, 64'h1);
    req(OPC_ALU, 3'b110, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'h0, NOP, 1'b1);
    idle(2);
    chk("cnt_after_alu", {48'h0, illegal_cnt_o}, 64'h2);
    req(OPC_ALU_I, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048, NOP, 1'b1);
    req(OPC_BRANCH, 3'b000, 7'h0, 5'd0, 5'd1, 5'd2, 32'd4096, NOP, 1'b1);
    req(OPC_LUI, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'h1234_5001, NOP, 1'b1);
    req(OPC_LW, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 32'd4, NOP, 1'b1);
    req(7'b1111111, 3'b000, 7'h0, 5'd1, 5'd2, 5'd0, 32'd0, NOP, 1'b1);
    idle(3);
    chk("cnt_after_all", {48'h0, illegal_cnt_o}, {48'h0, m_cnt});
    chk("cnt_value", {48'h0, illegal_cnt_o}, 64'h7);

    // Backpressure: buffer fills after two, third waits, order preserved
    do_reset();
    out_ready_i = 1'b0;
    req(OPC_ALU, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
    req(OPC_ALU, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b0);
    drive(OPC_LUI, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 32'h123450B7, 1'b0);
    chk("full_in_ready", {63'h0, in_ready_o}, 64'h0);
    step();
    chk("hold_valid", {63'h0, out_valid_o}, 64'h1);
    chk("hold_insn", {32'h0, out_insn_o}, 64'h002081B3);
    chk("hold_in_ready", {63'h0, in_ready_o}, 64'h0);
    out_ready_i = 1'b1;
    wait_accept();
    idle(4);
    chk("drained", 64'(sb.size()), 64'h0);
    chk("addr_after_three", {32'h0, out_addr_o}, 64'hC);

    // Address load concurrent with an output handshake
    req(OPC_ALU, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
    addr_load_i = 1'b1;
    addr_val_i  = 32'h0000_0103;
    req(OPC_SW, 3'b010, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
    addr_load_i = 1'b0;
    chk("addr_load", {32'h0, out_addr_o}, 64'h100);
    idle(2);
    chk("addr_after_load", {32'h0, out_addr_o}, 64'h104);

    // Reset with the buffer full
    out_ready_i = 1'b0;
    req(OPC_ALU, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
    req(OPC_ALU, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b0);
    in_valid_i = 1'b0;
    chk("pre_rst_full", {63'h0, in_ready_o}, 64'h0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sb.delete();
    m_addr = 32'h0;
    m_cnt  = 16'h0;
    chk("midrst_out_valid", {63'h0, out_valid_o}, 64'h0);
    chk("midrst_out_addr", {32'h0, out_addr_o}, 64'h0);
    chk("midrst_in_ready", {63'h0, in_ready_o}, 64'h1);
    chk("midrst_cnt", {48'h0, illegal_cnt_o}, 64'h0);
    out_ready_i = 1'b1;
    idle(2);
    chk("midrst_stays_empty", {63'h0, out_valid_o}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_insn_encoder.md
Name: riscv_insn_encoder

Overview:
- Instruction encoder for the supported RV32I subset (LW, ALU-I, AUIPC, SW, ALU, LUI, BRANCH). It is the reverse direction of the core's instruction decoder.
- Accepts decoded instruction fields on a valid/ready stream and emits packed 32-bit instruction words, each stamped with a sequential instruction-memory address.
- Used by the program loader and the self-test generator to fill IMEM. The verification bench also uses it as a golden encoder for decoder round-trip checks.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of the first emitted word after reset.
- ADDR_W, 32, width of the address counter and address ports.
- CNT_W, 16, width of the illegal-request counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  encoder can accept a request.
- in_opcode_i  in  7  opcode_t.
- in_f3_i  in  3  funct3: f3_alu_t or f3_branch_t.
- in_f7_i  in  7  f7_alu_modifier_t; used by ALU and by the ALU-I shift forms.
- in_rd_i  in  5  destination register.
- in_rs1_i  in  5  source register 1.
- in_rs2_i  in  5  source register 2.
- in_imm_i  in  32  full signed immediate value, not pre-shifted. U-type immediates are given as the full 32-bit value.
- out_valid_o  out  1  encoded word valid.
- out_ready_i  in  1  consumer accepts the word.
- out_insn_o  out  32  encoded instruction.
- out_addr_o  out  ADDR_W  IMEM address for out_insn_o.
- out_illegal_o  out  1  request was illegal; out_insn_o is the NOP word.
- addr_load_i  in  1  load the address counter.
- addr_val_i  in  ADDR_W  value to load; bits [1:0] are ignored and forced to 0.
- illegal_cnt_o  out  CNT_W  number of illegal requests emitted; saturates at all-ones.

Behaviour:
- Reset values: out_valid_o=0, out_insn_o=0, out_illegal_o=0, out_addr_o=BASE_ADDR, illegal_cnt_o=0, in_ready_o=1. Both buffer entries are emptied.
- Handshake rules:
  - A transfer occurs when valid and ready are both high.
  - out_valid_o and its data stay stable until accepted.
  - in_ready_o is a register output, with no combinational path from out_ready_i.
- Buffering: 2-entry skid buffer.
  - Main register plus skid register.
  - in_ready_o = !skid_full.
  - Latency: 1 cycle from input handshake to out_valid_o when the buffer is empty.
  - Full throughput (1 word/cycle) while out_ready_i=1.
  - When the buffer is full, a request is never dropped and never duplicated.
- Encoding (combinational, registered on input accept):
  - R (OP_ALU): f7|rs2|rs1|f3|rd|op.
  - I (OP_LW, OP_ALU_I): imm[11:0]|rs1|f3|rd|op.
    - ALU-I shifts (F3_SLL, F3_SRL_SRA): bits[31:25]=in_f7_i, bits[24:20]=imm[4:0].
  - S (OP_SW): imm[11:5]|rs2|rs1|010|imm[4:0]|op.
  - B (OP_BRANCH): imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U (OP_LUI, OP_AUIPC): imm[31:12]|rd|op.
  - Fields that a format does not use are ignored.
- Illegal requests. Any one of these makes the request illegal:
  - Unknown opcode.
  - OP_ALU with F7_ALU_MODIFIED and f3 not ADD_SUB/SRL_SRA, or with f7 not in f7_alu_modifier_t.
  - OP_ALU_I with F3_SLL and f7≠NORMAL.
  - OP_ALU_I with F3_SRL_SRA and f7 not in the enum.
  - OP_ALU_I shift with imm[31:5]≠0.
  - OP_LW/OP_SW with f3≠010.
  - I/S immediate outside [-2048, 2047].
  - OP_BRANCH with f3 = 010 or 011.
  - OP_BRANCH with odd immediate, or immediate outside [-4096, 4094].
  - U-type with imm[11:0]≠0.
- Illegal response:
  - out_insn_o = 32'h0000_0013 (addi x0,x0,0), out_illegal_o=1.
  - The address still advances.
  - illegal_cnt_o increments when the word is accepted at the output, saturating at all-ones.
- Address counter:
  - Stamped on out_addr_o for the head word.
  - +4 on each output handshake; wraps modulo 2^ADDR_W.
  - addr_load_i takes effect next cycle and wins over a same-cycle increment.
  - A word that is already buffered takes the new address if it is not yet accepted.
- Reset mid-operation: buffered words are discarded and the counter returns to BASE_ADDR.

Decomposition:
- Add to riscv_pkg:
  - INSN_NOP constant.
  - F3_LW_SW = 3'b010.
  - Immediate range constants (I_IMM_MIN/MAX, B_IMM_MIN/MAX).
  - enc_req_t struct {opcode, f3, f7, rd, rs1, rs2, imm}.
- One sub-module: riscv_skid_buffer, parameterised on the payload type, holding {insn, illegal}.
- Encode/legality checking stays a combinational function in the top module.

Test Plan:
- ALU requests:
  - ALU f3=000 f7=0 rd=3 rs1=1 rs2=2 -> 0x002081B3.
  - Same with f7=0100000 -> 0x402081B3.
  - out_addr_o 0x0 then 0x4.
- ALU_I / SW:
  - ALU_I f3=000 rd=5 rs1=0 imm=-1 -> 0xFFF00293.
  - SW rs1=1 rs2=2 imm=8 -> 0x0020A423.
- BRANCH / LUI:
  - BRANCH f3=000 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
  - LUI rd=1 imm=0x12345000 -> 0x123450B7.
- Illegal:
  - BRANCH imm=3 -> 0x00000013, out_illegal_o=1, illegal_cnt_o=1.
  - ALU f3=110 f7=0100000 -> NOP, illegal_cnt_o=2.
- Backpressure:
  - Hold out_ready_i=0 and drive 3 back-to-back requests -> in_ready_o=0 after 2 are accepted.
  - Release -> 3 words in order at addresses 0x0, 0x4, 0x8; no loss or duplication.
- Address load / reset:
  - addr_load_i with addr_val_i=0x103 concurrent with an output handshake -> next word at 0x100.
  - Assert rst_i with the buffer full -> out_valid_o=0 next cycle and out_addr_o=BASE_ADDR.
